// File: rtl/lnp_queue_scheduler.sv
// Round-robin scheduler for the last-node reassembly queues.
// Grants complete queues for forwarding and stale partial queues for discard,
// and keeps a saturating, prescaled age counter per queue.

module lnp_queue_age #(
   parameter int AGE_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             empty,
   input  logic             complete,
   input  logic             clr,
   input  logic             tick,
   input  logic [AGE_W-1:0] thr,
   output logic             timed_out
);
   logic [AGE_W-1:0] age;

   // Age clears when the queue is empty or freed; otherwise it counts ticks and saturates.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)               age <= '0;
      else if (empty || clr)      age <= '0;
      else if (tick && age != '1) age <= age + 1'b1;
   end

   // Only partial (non-empty, incomplete) queues can go stale; threshold 0 disables it.
   always_comb timed_out = !empty && !complete && (thr != '0) && (age >= thr);
endmodule

module lnp_queue_scheduler #(
   parameter int QUEUE_NUM = 32,
   parameter int QID_W     = 5,
   parameter int AGE_W     = 8,
   parameter int PRESCALE  = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [QUEUE_NUM-1:0] iv_queue_empty,
   input  logic [QUEUE_NUM-1:0] iv_queue_complete,
   input  logic [AGE_W-1:0]     iv_age_threshold,
   output logic [QID_W-1:0]     ov_sched_qid,
   output logic                 o_sched_discard,
   output logic                 o_sched_valid,
   input  logic                 i_sched_ack,
   input  logic                 i_sched_done,
   output logic                 o_sched_busy,
   output logic                 o_timeout_pulse
);
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_HOLD} state_t;

   state_t               state_q, state_d;
   logic [PRE_W-1:0]     pre_cnt;
   logic                 tick;
   logic [QID_W-1:0]     rr_q, rr_d, qid_d, winner, idx;
   logic                 disc_d, valid_d, pulse_d, found, served_done;
   logic [QUEUE_NUM-1:0] timed_out, cand;

   // Free-running age prescaler; tick on the wrap cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   always_comb tick = (pre_cnt == PRE_W'(PRESCALE - 1));

   // Consumer releasing the served queue resets that queue's age.
   always_comb served_done = (state_q == S_BUSY) && i_sched_done;

   genvar g;
   generate
      for (g = 0; g < QUEUE_NUM; g++) begin : g_q
         lnp_queue_age #(.AGE_W(AGE_W)) u_age (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .empty     (iv_queue_empty[g]),
            .complete  (iv_queue_complete[g]),
            .clr       (served_done && (ov_sched_qid == QID_W'(g))),
            .tick      (tick),
            .thr       (iv_age_threshold),
            .timed_out (timed_out[g])
         );
      end
   endgenerate

   // First candidate at or above rr_ptr, wrapping around the top.
   always_comb begin
      cand   = iv_queue_complete | timed_out;
      found  = 1'b0;
      winner = rr_q;
      idx    = '0;
      for (int i = 0; i < QUEUE_NUM; i++) begin
         idx = rr_q + QID_W'(i);
         if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // State and registered grant outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q         <= S_IDLE;
         rr_q            <= '0;
         ov_sched_qid    <= '0;
         o_sched_discard <= 1'b0;
         o_sched_valid   <= 1'b0;
         o_timeout_pulse <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_q            <= rr_d;
         ov_sched_qid    <= qid_d;
         o_sched_discard <= disc_d;
         o_sched_valid   <= valid_d;
         o_timeout_pulse <= pulse_d;
      end
   end

   // Next state; a grant is frozen until acked, so a winner bit dropping meanwhile is ignored.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      qid_d   = ov_sched_qid;
      disc_d  = o_sched_discard;
      valid_d = o_sched_valid;
      pulse_d = 1'b0;
      case (state_q)
         S_IDLE: if (found) begin
            qid_d   = winner;
            disc_d  = !iv_queue_complete[winner];
            valid_d = 1'b1;
            state_d = S_GRANT;
         end
         S_GRANT: if (i_sched_ack) begin
            valid_d = 1'b0;
            rr_d    = ov_sched_qid + QID_W'(1);
            pulse_d = o_sched_discard;
            state_d = S_BUSY;
         end
         S_BUSY: if (i_sched_done) state_d = S_HOLD;
         S_HOLD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign o_sched_busy = (state_q == S_GRANT) || (state_q == S_BUSY);
endmodule

// File: tb/tb_lnp_queue_scheduler.sv
// Bench for lnp_queue_scheduler: vector table, directed corner sequences and
// randomized traffic against a cycle-level model of the scheduling rules.

module tb_lnp_queue_scheduler;
   localparam int QN  = 32;
   localparam int PRE = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [31:0] empty = '1, complete = '0;
   logic [7:0]  thr = '0;
   logic [4:0]  qid;
   logic        disc, valid, ack = 1'b0, done = 1'b0, busy, pulse;

   int errors = 0, checks = 0;

   lnp_queue_scheduler #(.QUEUE_NUM(QN), .QID_W(5), .AGE_W(8), .PRESCALE(PRE)) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .iv_queue_empty    (empty),
      .iv_queue_complete (complete),
      .iv_age_threshold  (thr),
      .ov_sched_qid      (qid),
      .o_sched_discard   (disc),
      .o_sched_valid     (valid),
      .i_sched_ack       (ack),
      .i_sched_done      (done),
      .o_sched_busy      (busy),
      .o_timeout_pulse   (pulse)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      ack = 1'b0;
      done = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
   endtask

   // Reference model: phase 0=idle 1=granted 2=serving 3=settle
   int m_phase, m_qid, m_rr, m_pre;
   bit m_valid, m_disc, m_pulse;
   int m_age[QN];

   task automatic m_reset();
      m_phase = 0; m_qid = 0; m_rr = 0; m_pre = 0;
      m_valid = 0; m_disc = 0; m_pulse = 0;
      for (int q = 0; q < QN; q++) m_age[q] = 0;
   endtask

   task automatic m_step();
      bit tick;
      bit [31:0] cand;
      int freed;
      tick = (m_pre == PRE - 1);
      for (int q = 0; q < QN; q++)
         cand[q] = complete[q] ||
                   (!empty[q] && thr != 0 && m_age[q] >= int'(thr));
      freed = (m_phase == 2 && done) ? m_qid : -1;
      m_pulse = 0;
      case (m_phase)
         0: for (int i = 0; i < QN; i++) begin
               if (cand[(m_rr + i) % QN]) begin
                  m_qid = (m_rr + i) % QN;
                  m_disc = !complete[m_qid];
                  m_valid = 1;
                  m_phase = 1;
                  break;
               end
            end
         1: if (ack) begin
               m_valid = 0;
               m_rr = (m_qid + 1) % QN;
               m_pulse = m_disc;
               m_phase = 2;
            end
         2: if (done) m_phase = 3;
         default: m_phase = 0;
      endcase
      for (int q = 0; q < QN; q++) begin
         if (empty[q] || q == freed) m_age[q] = 0;
         else if (tick && m_age[q] < 255) m_age[q]++;
      end
      m_pre = tick ? 0 : m_pre + 1;
   endtask

   typedef struct {
      logic [31:0] cmp;
      logic        ack, done;
      logic        e_valid;
      logic [4:0]  e_qid;
      logic        e_disc, e_busy, e_pulse;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int cyc, grants;
      logic [31:0] ne, cp;

      // Tests 1/2: complete[3]; then 2 and 7 with rr_ptr=4; ack/done ignored in wrong state
      tbl[0]  = '{32'h08, 0, 0, 1, 5'd3, 0, 1, 0};
      tbl[1]  = '{32'h08, 1, 0, 0, 5'd3, 0, 1, 0};
      tbl[2]  = '{32'h00, 0, 1, 0, 5'd3, 0, 0, 0};
      tbl[3]  = '{32'h84, 0, 0, 0, 5'd3, 0, 0, 0};
      tbl[4]  = '{32'h84, 0, 0, 1, 5'd7, 0, 1, 0};
      tbl[5]  = '{32'h84, 1, 0, 0, 5'd7, 0, 1, 0};
      tbl[6]  = '{32'h84, 0, 1, 0, 5'd7, 0, 0, 0};
      tbl[7]  = '{32'h04, 0, 0, 0, 5'd7, 0, 0, 0};
      tbl[8]  = '{32'h04, 0, 0, 1, 5'd2, 0, 1, 0};
      tbl[9]  = '{32'h04, 1, 1, 0, 5'd2, 0, 1, 0};
      tbl[10] = '{32'h00, 1, 0, 0, 5'd2, 0, 1, 0};
      tbl[11] = '{32'h00, 0, 1, 0, 5'd2, 0, 0, 0};

      do_reset();
      chk("reset_valid", valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_pulse", pulse, 0);
      chk("reset_qid", qid, 0);
      chk("reset_disc", disc, 0);

      for (int r = 0; r < 12; r++) begin
         complete = tbl[r].cmp;
         empty = ~tbl[r].cmp;
         ack = tbl[r].ack;
         done = tbl[r].done;
         step();
         chk($sformatf("tbl%0d_valid", r), valid, tbl[r].e_valid);
         chk($sformatf("tbl%0d_qid", r), qid, tbl[r].e_qid);
         chk($sformatf("tbl%0d_disc", r), disc, tbl[r].e_disc);
         chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
         chk($sformatf("tbl%0d_pulse", r), pulse, tbl[r].e_pulse);
      end
      ack = 0; done = 0;

      // Test 3: partial queue 5, thr=3 -> ticks at edges 4,8,12, grant after edge 13
      complete = '0; empty = ~32'h20; thr = 8'd3;
      do_reset();
      cyc = 0;
      while (!valid && cyc < 60) begin
         step();
         cyc++;
      end
      chk("to_latency", cyc, 13);
      chk("to_qid", qid, 5);
      chk("to_disc", disc, 1);
      chk("to_pulse_pre", pulse, 0);
      ack = 1; step(); ack = 0;
      chk("to_pulse", pulse, 1);
      chk("to_valid_off", valid, 0);
      step();
      chk("to_pulse_1cyc", pulse, 0);
      done = 1; step(); done = 0;

      // Test 4: thr=0 for >1000 ticks -> no grant; then thr=255 grants at once (age saturated)
      thr = 8'd0;
      do_reset();
      grants = 0;
      for (int i = 0; i < 4100; i++) begin
         step();
         if (valid) grants++;
      end
      chk("thr0_no_grant", grants, 0);
      thr = 8'd255;
      step();
      chk("sat_valid", valid, 1);
      chk("sat_qid", qid, 5);
      chk("sat_disc", disc, 1);
      ack = 1; step(); ack = 0;
      done = 1; step(); done = 0;

      // Test 5: ack withheld, winner bit drops, done ignored in GRANT
      thr = 8'd0; complete = 32'h200; empty = ~32'h200;
      do_reset();
      step();
      chk("hold_start", valid, 1);
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin complete = '0; empty = '1; end
         done = (k == 6);
         step();
         chk($sformatf("hold%0d_valid", k), valid, 1);
         chk($sformatf("hold%0d_qid", k), qid, 9);
         chk($sformatf("hold%0d_disc", k), disc, 0);
      end
      done = 0; ack = 1; step(); ack = 0;
      chk("hold_ack_valid", valid, 0);
      chk("hold_ack_busy", busy, 1);
      chk("hold_ack_pulse", pulse, 0);

      // Test 6: async reset in GRANT and in BUSY; rr_ptr back to 0 afterwards
      complete = 32'h08; empty = ~32'h08;
      do_reset();
      step();
      chk("rst_g_valid_pre", valid, 1);
      ack = 1;
      #2 i_rst_n = 0;
      #1;
      chk("rst_g_valid", valid, 0);
      chk("rst_g_busy", busy, 0);
      step();
      chk("rst_g_pulse", pulse, 0);
      ack = 0;
      i_rst_n = 1;
      step();
      ack = 1; step(); ack = 0;
      chk("rst_b_busy_pre", busy, 1);
      #2 i_rst_n = 0;
      #1;
      chk("rst_b_busy", busy, 0);
      chk("rst_b_valid", valid, 0);
      complete = 32'h8000_0001; empty = ~32'h8000_0001;
      step();
      i_rst_n = 1;
      step();
      chk("rst_after_valid", valid, 1);
      chk("rst_after_qid", qid, 0);

      // Randomized traffic against the model
      complete = '0; empty = '1; thr = 8'd2;
      do_reset();
      m_reset();
      ne = '0; cp = '0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 250) thr = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 5) == 0) begin
            int q, s;
            q = $urandom_range(0, QN - 1);
            s = $urandom_range(0, 2);
            ne[q] = (s != 0);
            cp[q] = (s == 2);
         end
         empty = ~ne;
         complete = cp;
         ack = ($urandom_range(0, 2) == 0);
         done = ($urandom_range(0, 3) == 0);
         m_step();
         step();
         chk("rand_valid", valid, m_valid);
         chk("rand_qid", qid, m_qid);
         chk("rand_disc", disc, m_disc);
         chk("rand_busy", busy, (m_phase == 1 || m_phase == 2));
         chk("rand_pulse", pulse, m_pulse);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
